// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the tx and rx paths
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // 50 MHz system clock at 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte buffer between producer and transmitter
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   // a full buffer refuses a push even when a pop frees a slot on the same edge
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign level_o   = count_q;

   // storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - buffered 8-bit UART transmitter with optional parity
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DEPTH        = 4,
   parameter int PARITY       = PAR_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 iDATA,
   input  logic                       iVALID,
   output logic                       oREADY,
   output logic                       oTX,
   output logic                       oBUSY,
   output logic [$clog2(DEPTH):0]     oLEVEL
);

   localparam int            BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  sr_q, sr_d;
   logic        par_q, par_d;
   logic        stop_q, stop_d;
   logic        tx_q, tx_d;

   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_rd_data;
   logic        load;
   logic        bit_end;

   uart_tx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (iVALID),
      .wr_data_i (iDATA),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (oLEVEL)
   );

   assign oREADY  = !fifo_full;
   assign oTX     = tx_q;
   assign oBUSY   = (state_q != IDLE);
   assign bit_end = (baud_q == BAUD_LAST);

   // next-state logic; tx_d carries the line level of the state being entered
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q + BW'(1);
      idx_d    = idx_q;
      sr_d     = sr_q;
      par_d    = par_q;
      stop_d   = stop_q;
      tx_d     = tx_q;
      fifo_pop = 1'b0;
      load     = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            load   = 1'b1;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = 3'd0;
               baud_d  = '0;
               tx_d    = sr_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (idx_q == 3'd7) begin
                  if (PARITY != PAR_NONE) begin
                     state_d = uart_pkg::PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     stop_d  = 1'b0;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = sr_q[idx_q + 3'd1];
               end
            end
         end
         uart_pkg::PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               stop_d  = 1'b0;
               baud_d  = '0;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (STOP_BITS == 2 && !stop_q) begin
                  stop_d = 1'b1;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  load    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
         end
      endcase
      // a waiting byte starts its frame straight away, giving gapless bursts
      if (load && !fifo_empty) begin
         fifo_pop = 1'b1;
         sr_d     = fifo_rd_data;
         par_d    = (PARITY == PAR_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
         state_d  = START;
         baud_d   = '0;
         tx_d     = 1'b0;
      end
   end

   // state register; the serial line is a flop so it never glitches on inputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         sr_q    <= '0;
         par_q   <= 1'b0;
         stop_q  <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         sr_q    <= sr_d;
         par_q   <= par_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - scoreboard bench for uart_frame_tx across framing options
module tb_uart_frame_tx;

   localparam int CPB = 4;
   localparam int NI  = 4;
   // instance 0: no parity/1 stop, 1: even/1 stop, 2: odd/1 stop, 3: no parity/2 stop
   localparam logic [7:0] PAR_CFG  = {2'd0, 2'd1, 2'd2, 2'd0};
   localparam logic [7:0] STOP_CFG = {2'd2, 2'd1, 2'd1, 2'd1};

   typedef struct {
      int         inst;
      logic [7:0] data;
      logic       par;
      bit         b2b;
   } exp_t;

   exp_t exp_q[$];

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] din   = '0;
   logic [3:0]  valid = '0;
   wire  [3:0]  tx_w;
   wire  [3:0]  ready_w;
   wire  [3:0]  busy_w;
   wire  [11:0] level_w;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int next_start [NI];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : gen_dut
      localparam int P = int'(PAR_CFG[2*g +: 2]);
      localparam int S = int'(STOP_CFG[2*g +: 2]);

      uart_frame_tx #(
         .CLKS_PER_BIT (CPB),
         .DEPTH        (4),
         .PARITY       (P),
         .STOP_BITS    (S)
      ) dut (
         .clk    (clk),
         .reset  (reset),
         .iDATA  (din[8*g +: 8]),
         .iVALID (valid[g]),
         .oREADY (ready_w[g]),
         .oTX    (tx_w[g]),
         .oBUSY  (busy_w[g]),
         .oLEVEL (level_w[3*g +: 3])
      );

      // receiver model: checks every cycle of every bit against the expected frame
      initial begin : mon
         exp_t        e;
         logic [15:0] bits;
         logic [7:0]  rx;
         int          nb;
         int          st;
         bit          ok;
         bit          aborted;
         wait (reset == 1'b0);
         forever begin
            @(negedge tx_w[g]);
            if (reset) continue;
            if (exp_q.size() == 0 || exp_q[0].inst != g) begin
               chk($sformatf("unexpected_frame_inst%0d", g), 1, 0);
               continue;
            end
            e = exp_q.pop_front();
            bits = '1;
            bits[0] = 1'b0;
            bits[8:1] = e.data;
            if (P != 0) bits[9] = e.par;
            nb = 9 + ((P != 0) ? 1 : 0) + S;
            ok = 1'b1;
            aborted = 1'b0;
            rx = '0;
            st = 0;
            for (int b = 0; b < nb && !aborted; b++) begin
               for (int c = 0; c < CPB && !aborted; c++) begin
                  @(negedge clk);
                  if (b == 0 && c == 0) st = cyc;
                  if (reset) begin
                     aborted = 1'b1;
                  end else begin
                     if (tx_w[g] !== bits[b]) ok = 1'b0;
                     if (b >= 1 && b <= 8 && c == CPB/2) rx[b-1] = tx_w[g];
                  end
               end
            end
            if (aborted) begin
               wait (reset == 1'b0);
            end else begin
               checks++;
               if (!ok) begin
                  errors++;
                  $display("FAIL frame_inst%0d: got byte %02h with bad bit timing/levels, expected %02h par %0d",
                           g, rx, e.data, e.par);
               end
               if (e.b2b) chk($sformatf("b2b_start_inst%0d", g), st, next_start[g]);
               next_start[g] = st + nb * CPB;
            end
         end
      end
   end

   task automatic send(input int inst, input logic [7:0] d, input logic par, input bit b2b,
                       output int acc);
      int   n = 0;
      exp_t e;
      din[8*inst +: 8] = d;
      valid[inst] = 1'b1;
      while (!ready_w[inst] && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk("send_timeout", n, 0);
      @(posedge clk);
      e.inst = inst;
      e.data = d;
      e.par  = par;
      e.b2b  = b2b;
      exp_q.push_back(e);
      @(negedge clk);
      acc = cyc;
   endtask

   task automatic wait_idle(input int inst);
      int n = 0;
      while ((busy_w[inst] || level_w[3*inst +: 3] != 3'd0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("idle_timeout", n, 0);
      repeat (3) @(negedge clk);
   endtask

   // called on the negedge after an accept from empty: checks pop latency and frame length
   task automatic latency_and_len(input int inst, input int flen, input string tag);
      int n = 0;
      chk({tag, "_level_after_accept"}, int'(level_w[3*inst +: 3]), 1);
      chk({tag, "_tx_after_accept"}, int'(tx_w[inst]), 1);
      chk({tag, "_busy_after_accept"}, int'(busy_w[inst]), 0);
      @(negedge clk);
      chk({tag, "_tx_after_pop"}, int'(tx_w[inst]), 0);
      chk({tag, "_busy_after_pop"}, int'(busy_w[inst]), 1);
      chk({tag, "_level_after_pop"}, int'(level_w[3*inst +: 3]), 0);
      while (busy_w[inst] && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_frame_len"}, n, flen);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int acc;
      int acc0;
      int n;
      // reset state
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_tx_%0d", i), int'(tx_w[i]), 1);
         chk($sformatf("rst_busy_%0d", i), int'(busy_w[i]), 0);
         chk($sformatf("rst_ready_%0d", i), int'(ready_w[i]), 1);
         chk($sformatf("rst_level_%0d", i), int'(level_w[3*i +: 3]), 0);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1, 40 cycles
      send(0, 8'hA5, 1'b0, 1'b0, acc);
      valid[0] = 1'b0;
      latency_and_len(0, 40, "a5");
      wait_idle(0);

      // burst 0x00..0x05 with valid held; FIFO fills and a push on the pop edge is refused
      send(0, 8'h00, 1'b0, 1'b0, acc0);
      for (int b = 1; b <= 4; b++) send(0, 8'(b), 1'b0, 1'b1, acc);
      chk("burst_level_full", int'(level_w[2:0]), 4);
      chk("burst_ready_low", int'(ready_w[0]), 0);
      din[7:0] = 8'h05;
      n = 0;
      while (!ready_w[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("refused_push_ready_cycle", cyc, acc0 + 41);
      chk("refused_push_level", int'(level_w[2:0]), 3);
      send(0, 8'h05, 1'b0, 1'b1, acc);
      valid[0] = 1'b0;
      chk("burst_level_refill", int'(level_w[2:0]), 4);
      wait_idle(0);

      // even parity of 0x07 -> 1, odd parity -> 0; 44 cycles each
      send(1, 8'h07, 1'b1, 1'b0, acc);
      valid[1] = 1'b0;
      latency_and_len(1, 44, "even07");
      wait_idle(1);
      send(2, 8'h07, 1'b0, 1'b0, acc);
      valid[2] = 1'b0;
      latency_and_len(2, 44, "odd07");
      wait_idle(2);

      // two stop bits: 0xFF then 0x01 back to back, 44 cycles per frame
      send(3, 8'hFF, 1'b0, 1'b0, acc);
      send(3, 8'h01, 1'b0, 1'b1, acc);
      valid[3] = 1'b0;
      n = 0;
      while (busy_w[3] && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("stop2_busy_span", n, 88);
      wait_idle(3);

      // reset during data bit 3 with two bytes still queued
      send(0, 8'h3C, 1'b0, 1'b0, acc0);
      send(0, 8'h11, 1'b0, 1'b0, acc);
      send(0, 8'h22, 1'b0, 1'b0, acc);
      valid[0] = 1'b0;
      n = 0;
      while (cyc < acc0 + 1 + 17 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("pre_reset_level", int'(level_w[2:0]), 2);
      chk("pre_reset_tx_bit3", int'(tx_w[0]), 1);
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      chk("mid_reset_tx", int'(tx_w[0]), 1);
      chk("mid_reset_busy", int'(busy_w[0]), 0);
      chk("mid_reset_ready", int'(ready_w[0]), 1);
      chk("mid_reset_level", int'(level_w[2:0]), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      send(0, 8'h5A, 1'b0, 1'b0, acc);
      valid[0] = 1'b0;
      latency_and_len(0, 40, "post_reset");
      wait_idle(0);

      repeat (10) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Buffered 8-bit UART transmitter for the serial console path. It frames each byte as LSB-first serial data with one start bit, optional parity and one or two stop bits. Bytes come from a valid/ready producer, such as the command/echo logic or the TX data memory, into a small internal FIFO, so several bytes can be queued back-to-back. It is the transmit-side counterpart of `uart_rx`: same bit order, same framing, same bit period. A `uart_rx` built with matching parameters must decode its output losslessly.

## Interface
Parameters:
- CLKS_PER_BIT, 434 — clk cycles per serial bit (50 MHz / 115200); legal range ≥ 4
- DEPTH, 4 — FIFO entries; power of 2, ≥ 2
- PARITY, 0 — 0 none, 1 odd, 2 even
- STOP_BITS, 1 — 1 or 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears FIFO, FSM, counters
- iDATA  in  8  byte to send
- iVALID  in  1  iDATA valid this cycle
- oREADY  out  1  FIFO can accept; transfer occurs on a clock edge where iVALID && oREADY
- oTX  out  1  serial line, idle high, registered
- oBUSY  out  1  high from the first start-bit cycle through the last stop-bit cycle
- oLEVEL  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy count.
  - oREADY = (count != DEPTH), combinational from registered count.
  - Push and pop in the same cycle leave count unchanged.
  - When full, a push is refused even if a pop happens in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: oTX=1. If FIFO is non-empty, pop into shift register sr[7:0] and go to START.
  - START: oTX=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: oTX=sr[idx] for CLKS_PER_BIT cycles, idx 0..7 (LSB first). After idx 7, go to PARITY if PARITY≠0, else STOP.
  - PARITY: oTX = ^sr for even, ~^sr for odd; held CLKS_PER_BIT cycles, then STOP.
  - STOP: oTX=1 for STOP_BITS×CLKS_PER_BIT cycles. On the final cycle, if FIFO is non-empty, pop and go directly to START; else go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT).
  - Resets to 0 on every state/bit transition and counts to CLKS_PER_BIT-1.
  - No free-running divider: bit timing is aligned to frame start.
- Parity is computed over the popped byte, latched at pop time.
- iDATA changes after acceptance do not affect a queued or in-flight byte.

## Timing
- Reset values: oTX=1, oBUSY=0, oREADY=1, oLEVEL=0, state IDLE, pointers and counters 0.
- Reset asserted mid-frame: on assertion (async), oTX returns to 1, the frame is truncated, and all queued bytes are discarded.
- Latency from empty/IDLE:
  - Byte accepted at edge E; oLEVEL=1 after E.
  - Pop at edge E+1; oTX=0 and oBUSY=1 after E+1.
- Frame length: (1 + 8 + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, exactly.
- Back-to-back frames have zero idle cycles between the last stop cycle and the next start bit.
- oLEVEL decrements on the pop edge; oREADY rises in that same cycle.
- oBUSY falls on the edge where STOP ends with an empty FIFO.
- oTX is driven from a flop: no combinational path from any input to oTX.

## Structure
- Shared package `uart_pkg` holds:
  - state enum `tx_state_t` {IDLE, START, DATA, PARITY, STOP}
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
  - default CLKS_PER_BIT constant, shared with `uart_rx`
- One sub-module, `uart_tx_fifo`, parameterized by DEPTH and width 8. It provides push, pop, rd_data, full, empty and level. The FSM, shift register and baud counter stay in the top module.

## Test plan
Use CLKS_PER_BIT=4 unless noted. Sample oTX mid-bit and check against a `uart_rx` reference model.
- Single byte 0xA5, PARITY=0, STOP_BITS=1 → oTX sequence 0,1,0,1,0,0,1,0,1,1. Each level is held 4 cycles, frame is 40 cycles, and start is low 1 edge after the pop.
- Burst of 6 bytes 0x00..0x05 with iVALID held high, DEPTH=4:
  - oREADY drops when oLEVEL=4.
  - All 6 bytes are transmitted in order.
  - Frames are contiguous, with no high gap beyond the stop bit.
- PARITY=2 with 0x07 → parity bit 1. PARITY=1 with 0x07 → parity bit 0. Each frame is 44 cycles.
- STOP_BITS=2 with 0xFF → line high for 8+... cycles after data, and the next queued byte's start bit begins exactly 8 cycles after the last data bit ends.
- Full FIFO, push attempted on the same edge as a pop → the push is refused and oLEVEL goes 4→3.
- Reset pulse during DATA bit 3 → oTX=1 immediately, and oLEVEL=0, oBUSY=0, oREADY=1 after reset. The next byte then transmits with correct timing.
